reg_scoreboard: RTL

- Issue-side companion to the register file: tracks which architectural registers have writes in flight between decode issue and writeback.
- Gates decode issue on RAW hazards against those in-flight writes.
- Forwards same-cycle writeback data so a dependent instruction issues without waiting one cycle for the regfile write.
- Sits between the ID stage, which supplies read addresses and the destination, and the WB stage, which drives the regfile write port.

---
 rtl/reg_scoreboard.sv | 86 ++++++++
 1 files changed

// File: rtl/reg_scoreboard.sv
// Register scoreboard: counts in-flight writes per architectural register, stalls
// decode on RAW hazards and forwards same-cycle writeback data to the ID stage.
module reg_scoreboard #(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        id_valid,
  input  logic                        id_rs1_used,
  input  logic [REG_ADDR_W-1:0]       id_rs1_addr,
  input  logic                        id_rs2_used,
  input  logic [REG_ADDR_W-1:0]       id_rs2_addr,
  input  logic                        id_rd_wen,
  input  logic [REG_ADDR_W-1:0]       id_rd_addr,
  output logic                        id_ready,
  output logic                        rs1_fwd_en,
  output logic [XLEN-1:0]             rs1_fwd_data,
  output logic                        rs2_fwd_en,
  output logic [XLEN-1:0]             rs2_fwd_data,
  input  logic                        wb_en,
  input  logic [REG_ADDR_W-1:0]       wb_addr,
  input  logic [XLEN-1:0]             wb_data,
  input  logic                        flush,
  output logic [REG_ADDR_W+CNT_W-1:0] inflight,
  output logic                        sb_err
);

  localparam int unsigned NREG     = 1 << REG_ADDR_W;
  localparam int unsigned MAX_PEND = (1 << CNT_W) - 1;
  localparam int unsigned IF_W     = REG_ADDR_W + CNT_W;

  // Entry 0 is never incremented, so x0 always reads as not pending.
  logic [NREG-1:0][CNT_W-1:0] pend_q, pend_d;
  logic [IF_W-1:0]            inflight_d;
  logic fwd1, fwd2, haz1, haz2, full, fire, err_set;

  // Forwarding is only legal when the writeback is the youngest outstanding write.
  always_comb begin
    fwd1 = id_rs1_used && wb_en && (wb_addr == id_rs1_addr) && (id_rs1_addr != '0)
           && (pend_q[id_rs1_addr] == CNT_W'(1));
    fwd2 = id_rs2_used && wb_en && (wb_addr == id_rs2_addr) && (id_rs2_addr != '0)
           && (pend_q[id_rs2_addr] == CNT_W'(1));
    haz1 = id_rs1_used && (id_rs1_addr != '0) && (pend_q[id_rs1_addr] != '0) && !fwd1;
    haz2 = id_rs2_used && (id_rs2_addr != '0) && (pend_q[id_rs2_addr] != '0) && !fwd2;
    full = id_rd_wen && (id_rd_addr != '0) && (pend_q[id_rd_addr] == CNT_W'(MAX_PEND));
    fire = id_valid && !flush && !haz1 && !haz2 && !full;
    err_set = wb_en && (wb_addr != '0) && (pend_q[wb_addr] == '0) && !flush;
  end

  assign id_ready     = !flush && !haz1 && !haz2 && !full;
  assign rs1_fwd_en   = fwd1;
  assign rs2_fwd_en   = fwd2;
  assign rs1_fwd_data = wb_data;
  assign rs2_fwd_data = wb_data;

  // Next counter values; a matching issue and retire in one cycle cancel out.
  always_comb begin
    pend_d     = pend_q;
    inflight_d = '0;
    for (int unsigned i = 1; i < NREG; i++) begin
      if (flush) begin
        pend_d[i] = '0;
      end else begin
        pend_d[i] = pend_q[i]
                  + CNT_W'(fire && id_rd_wen && (id_rd_addr == REG_ADDR_W'(i)))
                  - CNT_W'(wb_en && (wb_addr == REG_ADDR_W'(i)) && (pend_q[i] != '0));
      end
      inflight_d = inflight_d + IF_W'(pend_d[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q   <= '0;
      inflight <= '0;
      sb_err   <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      inflight <= inflight_d;
      if (err_set) sb_err <= 1'b1;
    end
  end

endmodule
